// File: rtl/can_tx_fifo_if.sv
// Host/transmitter-facing signal bundle of the CAN FD transmit frame FIFO.
// The master side is the host and bit-stream transmitter. The slave side is the FIFO.
interface can_tx_fifo_if #(
  parameter int INFO_LOG2 = 4
);
  logic                 reset_mode;
  logic                 wr;
  logic [31:0]          data_in;
  logic                 commit;
  logic                 discard;
  logic                 clr_overflow;
  logic                 rd;
  logic                 tx_done;
  logic                 abort;
  logic                 tx_retry;
  logic [31:0]          data_out;
  logic [4:0]           frame_len;
  logic                 tx_request;
  logic [INFO_LOG2:0]   frame_cnt;
  logic                 tx_full;
  logic                 overflow;

  modport master (
    output reset_mode, wr, data_in, commit, discard, clr_overflow,
           rd, tx_done, abort, tx_retry,
    input  data_out, frame_len, tx_request, frame_cnt, tx_full, overflow
  );

  modport slave (
    input  reset_mode, wr, data_in, commit, discard, clr_overflow,
           rd, tx_done, abort, tx_retry,
    output data_out, frame_len, tx_request, frame_cnt, tx_full, overflow
  );
endinterface

// File: rtl/can_tx_fifo.sv
// Transmit frame FIFO: the host builds frames word by word and commits them whole.
// The transmitter walks the head frame, then releases it or rewinds it for a retry.
module can_tx_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int INFO_LOG2  = 4,
  parameter int MAX_WORDS  = 18
) (
  input  logic         clk,
  input  logic         rst,
  can_tx_fifo_if.slave bus
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int INFO_DEPTH = 1 << INFO_LOG2;
  localparam int CW         = DEPTH_LOG2 + 1;
  localparam int FW         = INFO_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [FW-1:0] QUEUE_MAX = FW'(INFO_DEPTH);
  localparam logic [4:0]    MAXW      = 5'(MAX_WORDS);

  logic [31:0] mem    [DEPTH];
  logic [4:0]  lenMem [INFO_DEPTH];

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] openStart_q, openStart_d;
  logic [DEPTH_LOG2-1:0] headPtr_q, headPtr_d;
  logic [4:0]            wordIdx_q, wordIdx_d;
  logic [CW-1:0]         wordCnt_q, wordCnt_d;
  logic [4:0]            openLen_q, openLen_d;
  logic                  openBad_q, openBad_d;
  logic [INFO_LOG2-1:0]  lenRd_q, lenRd_d;
  logic [INFO_LOG2-1:0]  lenWr_q, lenWr_d;
  logic [FW-1:0]         frameCnt_q, frameCnt_d;
  logic                  overflow_q, overflow_d;

  logic                  clear;
  logic                  frameValid;
  logic [4:0]            headLen;
  logic                  txFull;
  logic                  queueFull;
  logic                  relHead;
  logic                  retryHead;
  logic                  rdAdv;
  logic                  hostBusy;
  logic                  wrAcc;
  logic                  wrDrop;
  logic                  commitOk;
  logic                  commitDrop;
  logic                  dropOpen;
  logic [4:0]            rdOff;
  logic [DEPTH_LOG2-1:0] rdAddr;

  always_comb begin
    clear      = rst | bus.reset_mode;
    frameValid = (frameCnt_q != '0);
    headLen    = frameValid ? lenMem[lenRd_q] : 5'd0;
    txFull     = (wordCnt_q == FULL_CNT);
    queueFull  = (frameCnt_q == QUEUE_MAX);
    relHead    = (bus.tx_done | bus.abort) & frameValid;
    retryHead  = bus.tx_retry & frameValid & ~relHead;
    rdAdv      = bus.rd & frameValid & ~relHead & ~retryHead & (wordIdx_q < headLen);
    hostBusy   = bus.commit | bus.discard;
    // A release in the same cycle frees at least one word, so a write is safe even when full.
    wrAcc      = bus.wr & ~hostBusy & (~txFull | relHead) & (openLen_q < MAXW);
    wrDrop     = bus.wr & ~hostBusy & ~wrAcc;
    commitOk   = bus.commit & ~openBad_q & (openLen_q != 5'd0) & ~queueFull;
    commitDrop = bus.commit & (openBad_q | (queueFull & (openLen_q != 5'd0)));
    dropOpen   = commitDrop | (bus.discard & ~bus.commit);
    // Past the last word the read stays on it, so uncommitted data never shows.
    rdOff      = (wordIdx_q < headLen) ? wordIdx_q : (headLen - 5'd1);
    rdAddr     = headPtr_q + DEPTH_LOG2'(rdOff);
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    openStart_d = openStart_q;
    headPtr_d   = headPtr_q;
    wordIdx_d   = wordIdx_q;
    openLen_d   = openLen_q;
    openBad_d   = openBad_q;
    lenRd_d     = lenRd_q;
    lenWr_d     = lenWr_q;
    overflow_d  = overflow_q;

    if (wrAcc) begin
      wrPtr_d   = wrPtr_q + 1'b1;
      openLen_d = openLen_q + 5'd1;
    end
    if (commitOk) begin
      openStart_d = wrPtr_q;
      openLen_d   = 5'd0;
      lenWr_d     = lenWr_q + 1'b1;
    end
    if (dropOpen) begin
      wrPtr_d   = openStart_q;
      openLen_d = 5'd0;
      openBad_d = 1'b0;
    end else if (wrDrop) begin
      openBad_d = 1'b1;
    end

    if (relHead) begin
      headPtr_d = headPtr_q + DEPTH_LOG2'(headLen);
      wordIdx_d = 5'd0;
      lenRd_d   = lenRd_q + 1'b1;
    end else if (retryHead) begin
      wordIdx_d = 5'd0;
    end else if (rdAdv) begin
      wordIdx_d = wordIdx_q + 5'd1;
    end

    wordCnt_d  = wordCnt_q + CW'(wrAcc)
               - (dropOpen ? CW'(openLen_q) : '0)
               - (relHead ? CW'(headLen) : '0);
    frameCnt_d = frameCnt_q + FW'(commitOk) - FW'(relHead);

    if (commitDrop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wrPtr_q     <= '0;
      openStart_q <= '0;
      headPtr_q   <= '0;
      wordIdx_q   <= '0;
      wordCnt_q   <= '0;
      openLen_q   <= '0;
      openBad_q   <= 1'b0;
      lenRd_q     <= '0;
      lenWr_q     <= '0;
      frameCnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      openStart_q <= openStart_d;
      headPtr_q   <= headPtr_d;
      wordIdx_q   <= wordIdx_d;
      wordCnt_q   <= wordCnt_d;
      openLen_q   <= openLen_d;
      openBad_q   <= openBad_d;
      lenRd_q     <= lenRd_d;
      lenWr_q     <= lenWr_d;
      frameCnt_q  <= frameCnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is never cleared; reset only makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (wrAcc && !clear) begin
      mem[wrPtr_q] <= bus.data_in;
    end
    if (commitOk && !clear) begin
      lenMem[lenWr_q] <= openLen_q;
    end
  end

  assign bus.data_out   = frameValid ? mem[rdAddr] : 32'd0;
  assign bus.frame_len  = headLen;
  assign bus.tx_request = frameValid;
  assign bus.frame_cnt  = frameCnt_q;
  assign bus.tx_full    = txFull;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_can_tx_fifo.sv
// Directed self-checking bench for can_tx_fifo: frame build/commit, readout,
// retry, overflow, discard, pointer wrap and reset_mode behaviour.
module tb_can_tx_fifo;

  localparam int W   = 1;
  localparam int CM  = 2;
  localparam int DS  = 4;
  localparam int CLR = 8;
  localparam int RD  = 16;
  localparam int TD  = 32;
  localparam int AB  = 64;
  localparam int RT  = 128;
  localparam int RM  = 256;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  can_tx_fifo_if #(.INFO_LOG2(4)) bus ();

  can_tx_fifo #(
    .DEPTH_LOG2(6),
    .INFO_LOG2 (4),
    .MAX_WORDS (18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Drive one cycle of controls, let the edge sample them, then go idle.
  task automatic applyStimulus(input int ctl, input logic [31:0] data);
    bus.wr           = ctl[0];
    bus.commit       = ctl[1];
    bus.discard      = ctl[2];
    bus.clr_overflow = ctl[3];
    bus.rd           = ctl[4];
    bus.tx_done      = ctl[5];
    bus.abort        = ctl[6];
    bus.tx_retry     = ctl[7];
    bus.reset_mode   = ctl[8];
    bus.data_in      = data;
    @(posedge clk);
    #1;
    bus.wr           = 1'b0;
    bus.commit       = 1'b0;
    bus.discard      = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.rd           = 1'b0;
    bus.tx_done      = 1'b0;
    bus.abort        = 1'b0;
    bus.tx_retry     = 1'b0;
    bus.reset_mode   = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic writeWords(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(W, base + 32'(i));
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req"},  32'(bus.tx_request), 32'd0);
    checkOutput({tag, "_cnt"},  32'(bus.frame_cnt),  32'd0);
    checkOutput({tag, "_len"},  32'(bus.frame_len),  32'd0);
    checkOutput({tag, "_full"}, 32'(bus.tx_full),    32'd0);
    checkOutput({tag, "_ovf"},  32'(bus.overflow),   32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    bus.wr = 1'b0; bus.commit = 1'b0; bus.discard = 1'b0; bus.clr_overflow = 1'b0;
    bus.rd = 1'b0; bus.tx_done = 1'b0; bus.abort = 1'b0; bus.tx_retry = 1'b0;
    bus.reset_mode = 1'b0; bus.data_in = 32'd0;
    @(posedge clk);
    #1;
    resetDut();
    checkIdle("reset");

    // Basic frame: write, commit, read out, release
    writeWords(32'hA1, 1);
    applyStimulus(W, 32'hB2);
    applyStimulus(W, 32'hC3);
    checkOutput("open_not_presented", 32'(bus.tx_request), 32'd0);
    applyStimulus(CM, 32'd0);
    checkOutput("t1_req", 32'(bus.tx_request), 32'd1);
    checkOutput("t1_cnt", 32'(bus.frame_cnt), 32'd1);
    checkOutput("t1_len", 32'(bus.frame_len), 32'd3);
    checkOutput("t1_d0", bus.data_out, 32'hA1);
    applyStimulus(RD, 32'd0);
    checkOutput("t1_d1", bus.data_out, 32'hB2);
    applyStimulus(RD, 32'd0);
    checkOutput("t1_d2", bus.data_out, 32'hC3);
    applyStimulus(RD, 32'd0);
    checkOutput("t1_hold", bus.data_out, 32'hC3);
    applyStimulus(TD, 32'd0);
    checkOutput("t1_done_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("t1_done_req", 32'(bus.tx_request), 32'd0);
    checkOutput("t1_done_wcnt", 32'(dut.wordCnt_q), 32'd0);

    // Retry rewinds and wins over a simultaneous rd
    resetDut();
    writeWords(32'h10, 4);
    applyStimulus(CM, 32'd0);
    applyStimulus(RD, 32'd0);
    applyStimulus(RD, 32'd0);
    checkOutput("t2_d2", bus.data_out, 32'h12);
    applyStimulus(RT | RD, 32'd0);
    checkOutput("t2_retry_d0", bus.data_out, 32'h10);
    checkOutput("t2_retry_len", 32'(bus.frame_len), 32'd4);
    applyStimulus(RD, 32'd0);
    checkOutput("t2_after_rd", bus.data_out, 32'h11);
    applyStimulus(AB, 32'd0);
    checkOutput("t2_abort_cnt", 32'(bus.frame_cnt), 32'd0);

    // Fill storage, then overflow on the extra frame
    resetDut();
    for (int f = 0; f < 4; f++) begin
      writeWords(32'h300 + 32'(f * 16), 16);
      applyStimulus(CM, 32'd0);
    end
    checkOutput("t3_cnt4", 32'(bus.frame_cnt), 32'd4);
    checkOutput("t3_full", 32'(bus.tx_full), 32'd1);
    applyStimulus(W, 32'hDEAD);
    checkOutput("t3_open_bad", 32'(dut.openBad_q), 32'd1);
    checkOutput("t3_ovf_pre", 32'(bus.overflow), 32'd0);
    applyStimulus(CM, 32'd0);
    checkOutput("t3_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("t3_cnt_kept", 32'(bus.frame_cnt), 32'd4);
    checkOutput("t3_head", bus.data_out, 32'h300);

    // Oversized frame is dropped at commit
    resetDut();
    writeWords(32'h400, 19);
    checkOutput("t4_wcnt18", 32'(dut.wordCnt_q), 32'd18);
    applyStimulus(CM, 32'd0);
    checkOutput("t4_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("t4_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("t4_wcnt0", 32'(dut.wordCnt_q), 32'd0);
    applyStimulus(CLR, 32'd0);
    checkOutput("t4_clr", 32'(bus.overflow), 32'd0);

    // Discard rewinds the open frame
    resetDut();
    writeWords(32'hA0, 2);
    applyStimulus(CM, 32'd0);
    writeWords(32'hD0, 5);
    checkOutput("t5_wcnt7", 32'(dut.wordCnt_q), 32'd7);
    applyStimulus(DS, 32'd0);
    checkOutput("t5_wcnt2", 32'(dut.wordCnt_q), 32'd2);
    applyStimulus(W, 32'h77);
    applyStimulus(CM, 32'd0);
    checkOutput("t5_cnt2", 32'(bus.frame_cnt), 32'd2);
    applyStimulus(TD, 32'd0);
    checkOutput("t5_len", 32'(bus.frame_len), 32'd1);
    checkOutput("t5_restart", bus.data_out, 32'h77);

    // Walk the pointers to 60, then a 10-word frame wraps to address 5
    resetDut();
    for (int f = 0; f < 4; f++) begin
      writeWords(32'h500, 15);
      applyStimulus(CM, 32'd0);
      applyStimulus(TD, 32'd0);
    end
    checkOutput("t6_head60", 32'(dut.headPtr_q), 32'd60);
    writeWords(32'h600, 10);
    applyStimulus(CM, 32'd0);
    checkOutput("t6_len", 32'(bus.frame_len), 32'd10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t6_word%0d", i), bus.data_out, 32'h600 + 32'(i));
      applyStimulus(RD, 32'd0);
    end
    applyStimulus(TD | W, 32'h700);
    checkOutput("t6_wcnt", 32'(dut.wordCnt_q), 32'd1);
    checkOutput("t6_cnt0", 32'(bus.frame_cnt), 32'd0);
    applyStimulus(CM, 32'd0);
    checkOutput("t6_next", bus.data_out, 32'h700);
    writeWords(32'h800, 2);
    applyStimulus(RM, 32'd0);
    checkIdle("rm1");
    checkOutput("rm1_data", bus.data_out, 32'd0);
    applyStimulus(RM | W | CM, 32'h900);
    applyStimulus(RM, 32'd0);
    checkIdle("rm3");
    applyStimulus(W, 32'hBEEF);
    applyStimulus(CM, 32'd0);
    checkOutput("resume_cnt", 32'(bus.frame_cnt), 32'd1);
    checkOutput("resume_data", bus.data_out, 32'hBEEF);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
